// File: rtl/multi_ch_capture_if.sv
// Bundle of the capture block's data, config, RAM and readout signals.
// The slave modport is the capture block; the master modport is whatever
// drives it (ADC front end, command logic, channel RAM, UART response path).
interface multi_ch_capture_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                     smpl_en;
    logic [NUM_CH*DATA_W-1:0] smpl_data;
    logic [NUM_CH-1:0]        trig_in;
    logic [CH_W-1:0]          cfg_trig_src;
    logic                     cfg_trig_edge;
    logic [ADDR_W-1:0]        cfg_trig_pos;
    logic [3:0]               cfg_decimator;
    logic                     arm;
    logic                     dump;
    logic [CH_W-1:0]          dump_ch;
    logic                     clr_cap_done;
    logic                     ram_en;
    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_addr;
    logic [NUM_CH*DATA_W-1:0] ram_wdata;
    logic [NUM_CH*DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0]        dout;
    logic                     dout_vld;
    logic                     dout_rdy;
    logic                     busy;
    logic                     cap_done;
    logic                     dump_fin;
    logic                     auto_trig;

    modport slave (
        input  smpl_en, smpl_data, trig_in, cfg_trig_src, cfg_trig_edge,
               cfg_trig_pos, cfg_decimator, arm, dump, dump_ch, clr_cap_done,
               ram_rdata, dout_rdy,
        output ram_en, ram_we, ram_addr, ram_wdata, dout, dout_vld,
               busy, cap_done, dump_fin, auto_trig
    );

    modport master (
        output smpl_en, smpl_data, trig_in, cfg_trig_src, cfg_trig_edge,
               cfg_trig_pos, cfg_decimator, arm, dump, dump_ch, clr_cap_done,
               ram_rdata, dout_rdy,
        input  ram_en, ram_we, ram_addr, ram_wdata, dout, dout_vld,
               busy, cap_done, dump_fin, auto_trig
    );
endinterface

// File: rtl/multi_ch_capture.sv
// Multi-channel scope capture into an external circular RAM, with
// decimation, edge trigger and post-trigger depth, plus in-order readout of
// one channel over a valid/ready port.
// Optional macro AUTO_TRIG_EN: forces a trigger after AUTO_TIMEOUT kept
// samples in ARMED and reports it on auto_trig.
//
// state | meaning
// IDLE  | nothing captured since reset
// PRE   | filling pre-trigger history, edges ignored
// ARMED | writing, waiting for the trigger sample
// POST  | writing the post-trigger samples
// DONE  | capture complete, buffer stable
// DUMP  | streaming one channel from the oldest sample
module multi_ch_capture #(
    parameter int NUM_CH       = 3,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 512,
    parameter int MAX_DEC      = 15,
    parameter int AUTO_TIMEOUT = 4096
) (
    input logic               clk,
    input logic               rst,
    multi_ch_capture_if.slave bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DCNT_W = (MAX_DEC > 0) ? MAX_DEC : 1;
    localparam int TO_W   = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_DUMP} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   trig_s1_q, trig_s1_d, trig_s2_q, trig_s2_d;
    logic                trig_prev_q, trig_prev_d, trig_seen_q, trig_seen_d;
    logic [CH_W-1:0]     src_q, src_d, dump_ch_q, dump_ch_d;
    logic                rise_q, rise_d;
    logic [ADDR_W-1:0]   pos_q, pos_d;
    logic [3:0]          dec_q, dec_d;
    logic [DCNT_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]   start_addr_q, start_addr_d, rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
    logic                need_rd_q, need_rd_d, rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_vld_q, dout_vld_d, busy_q, busy_d;
    logic                cap_done_q, cap_done_d, dump_fin_q, dump_fin_d;
`ifdef AUTO_TRIG_EN
    logic [TO_W-1:0]     arm_cnt_q, arm_cnt_d;
    logic                auto_trig_q, auto_trig_d;
`endif

    logic                trig_lvl, edge_det, trig_hit, force_trig;
    logic                capturing, arm_take, kept, hs, last, rd_issue, done_entry;
    logic [DCNT_W-1:0]   dec_mask;
    logic [ADDR_W-1:0]   pre_nxt, post_nxt;
    logic [3:0]          dec_eff;
    int                  rd_idx;

    // Next-state logic for the capture FSM, pointers, counters and readout.
    always_comb begin
        state_d      = state_q;
        trig_s1_d    = bus.trig_in;
        trig_s2_d    = trig_s1_q;
        trig_prev_d  = trig_s2_q[src_q];
        trig_seen_d  = trig_seen_q;
        src_d        = src_q;
        rise_d       = rise_q;
        pos_d        = pos_q;
        dec_d        = dec_q;
        dec_cnt_d    = dec_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        start_addr_d = start_addr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_cnt_d     = rd_cnt_q;
        dump_ch_d    = dump_ch_q;
        need_rd_d    = need_rd_q;
        rd_pend_d    = 1'b0;
        dout_d       = dout_q;
        dout_vld_d   = dout_vld_q;
        cap_done_d   = cap_done_q;
        dump_fin_d   = 1'b0;
        done_entry   = 1'b0;
        force_trig   = 1'b0;
`ifdef AUTO_TRIG_EN
        arm_cnt_d    = arm_cnt_q;
        auto_trig_d  = auto_trig_q;
`endif

        trig_lvl  = trig_s2_q[src_q];
        edge_det  = rise_q ? (trig_lvl & ~trig_prev_q) : (~trig_lvl & trig_prev_q);
        trig_hit  = trig_seen_q | edge_det;
        capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
        arm_take  = bus.arm && (state_q != S_DUMP);
        kept      = capturing && bus.smpl_en && (dec_cnt_q == '0) && !arm_take;
        hs        = (state_q == S_DUMP) && dout_vld_q && bus.dout_rdy;
        last      = (rd_cnt_q == ADDR_W'(DEPTH - 1));
        rd_issue  = (state_q == S_DUMP) && (need_rd_q || (hs && !last));
        dec_mask  = ~({DCNT_W{1'b1}} << dec_q);
        pre_nxt   = pre_cnt_q + 1'b1;
        post_nxt  = post_cnt_q + 1'b1;
        rd_idx    = int'(dump_ch_q);
        dec_eff   = (int'(bus.cfg_decimator) > MAX_DEC) ? 4'(MAX_DEC) : bus.cfg_decimator;

        if (capturing && bus.smpl_en)
            dec_cnt_d = (dec_cnt_q == dec_mask) ? '0 : dec_cnt_q + 1'b1;
        if (kept)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (state_q == S_ARMED && edge_det)
            trig_seen_d = 1'b1;
        if (kept)
            trig_seen_d = 1'b0;

        case (state_q)
            S_PRE: if (kept) begin
                pre_cnt_d = pre_nxt;
                if (pre_nxt == ADDR_W'(DEPTH - 1) - pos_q)
                    state_d = S_ARMED;
            end
            S_ARMED: if (kept) begin
`ifdef AUTO_TRIG_EN
                arm_cnt_d = arm_cnt_q + 1'b1;
                if (!trig_hit && (arm_cnt_q + 1'b1 == TO_W'(AUTO_TIMEOUT))) begin
                    force_trig  = 1'b1;
                    auto_trig_d = 1'b1;
                end
`endif
                if (trig_hit || force_trig) begin
                    post_cnt_d = '0;
                    if (pos_q == '0) begin
                        state_d    = S_DONE;
                        done_entry = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: if (kept) begin
                post_cnt_d = post_nxt;
                if (post_nxt == pos_q) begin
                    state_d    = S_DONE;
                    done_entry = 1'b1;
                end
            end
            S_DONE: if (bus.dump) begin
                state_d   = S_DUMP;
                rd_ptr_d  = start_addr_q;
                rd_cnt_d  = '0;
                need_rd_d = 1'b1;
                dump_ch_d = bus.dump_ch;
            end
            S_DUMP: begin
                if (rd_issue) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    need_rd_d = 1'b0;
                    rd_pend_d = 1'b1;
                end
                if (rd_pend_q) begin
                    dout_d     = (rd_idx < NUM_CH) ? bus.ram_rdata[rd_idx*DATA_W +: DATA_W] : '0;
                    dout_vld_d = 1'b1;
                end
                if (hs) begin
                    dout_vld_d = 1'b0;
                    rd_cnt_d   = rd_cnt_q + 1'b1;
                    if (last) begin
                        dump_fin_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            default: ;
        endcase

        // The write pointer after the final write points at the oldest sample.
        if (done_entry)
            start_addr_d = wr_ptr_d;

        if (bus.clr_cap_done || arm_take)
            cap_done_d = 1'b0;
        if (done_entry)
            cap_done_d = 1'b1;

        if (arm_take) begin
            state_d     = (bus.cfg_trig_pos == ADDR_W'(DEPTH - 1)) ? S_ARMED : S_PRE;
            wr_ptr_d    = '0;
            pre_cnt_d   = '0;
            post_cnt_d  = '0;
            dec_cnt_d   = '0;
            trig_seen_d = 1'b0;
            src_d       = bus.cfg_trig_src;
            rise_d      = bus.cfg_trig_edge;
            pos_d       = bus.cfg_trig_pos;
            dec_d       = dec_eff;
`ifdef AUTO_TRIG_EN
            arm_cnt_d   = '0;
            auto_trig_d = 1'b0;
`endif
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            trig_s1_q    <= '0;
            trig_s2_q    <= '0;
            trig_prev_q  <= 1'b0;
            trig_seen_q  <= 1'b0;
            src_q        <= '0;
            rise_q       <= 1'b0;
            pos_q        <= '0;
            dec_q        <= '0;
            dec_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            start_addr_q <= '0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            dump_ch_q    <= '0;
            need_rd_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            cap_done_q   <= 1'b0;
            dump_fin_q   <= 1'b0;
`ifdef AUTO_TRIG_EN
            arm_cnt_q    <= '0;
            auto_trig_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            trig_s1_q    <= trig_s1_d;
            trig_s2_q    <= trig_s2_d;
            trig_prev_q  <= trig_prev_d;
            trig_seen_q  <= trig_seen_d;
            src_q        <= src_d;
            rise_q       <= rise_d;
            pos_q        <= pos_d;
            dec_q        <= dec_d;
            dec_cnt_q    <= dec_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            start_addr_q <= start_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            dump_ch_q    <= dump_ch_d;
            need_rd_q    <= need_rd_d;
            rd_pend_q    <= rd_pend_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            busy_q       <= busy_d;
            cap_done_q   <= cap_done_d;
            dump_fin_q   <= dump_fin_d;
`ifdef AUTO_TRIG_EN
            arm_cnt_q    <= arm_cnt_d;
            auto_trig_q  <= auto_trig_d;
`endif
        end
    end

    // RAM strobes are combinational so a kept sample is written in its own cycle.
    assign bus.ram_en    = kept | rd_issue;
    assign bus.ram_we    = kept;
    assign bus.ram_addr  = kept ? wr_ptr_q : rd_ptr_q;
    assign bus.ram_wdata = bus.smpl_data;
    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.busy      = busy_q;
    assign bus.cap_done  = cap_done_q;
    assign bus.dump_fin  = dump_fin_q;
`ifdef AUTO_TRIG_EN
    assign bus.auto_trig = auto_trig_q;
`else
    assign bus.auto_trig = 1'b0;
`endif
endmodule

// File: doc/multi_ch_capture.md
Name: multi_ch_capture

Overview:
Parametrised successor to the fixed 3-channel scope capture path. Records NUM_CH channels of DATA_W-bit ADC samples into an external circular RAM, with programmable decimation, trigger source, trigger edge and post-trigger depth. After a capture completes, streams one selected channel back in chronological order over a valid/ready port toward the UART response path. Sits between the ADC/AFE front end, the channel RAM, and the command/config logic.

Parameters:
NUM_CH, 3, number of capture channels (1..8); CH_W = max(1,$clog2(NUM_CH))
DATA_W, 8, bits per sample
DEPTH, 512, samples per channel; power of two; ADDR_W = $clog2(DEPTH)
MAX_DEC, 15, largest legal cfg_decimator value
AUTO_TIMEOUT, 4096, kept samples before a forced trigger (used only with AUTO_TRIG_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
smpl_en  in  1  one-clock strobe, new ADC sample valid on smpl_data
smpl_data  in  NUM_CH*DATA_W  channel k in bits [k*DATA_W +: DATA_W]
trig_in  in  NUM_CH  asynchronous trigger comparator outputs
cfg_trig_src  in  CH_W  trigger channel select
cfg_trig_edge  in  1  1=rising, 0=falling
cfg_trig_pos  in  ADDR_W  samples kept after the trigger sample
cfg_decimator  in  4  keep 1 of every 2^cfg_decimator samples
arm  in  1  pulse, start capture
dump  in  1  pulse, start readout
dump_ch  in  CH_W  channel to read out
clr_cap_done  in  1  clear cap_done
ram_en, ram_we  out  1  RAM strobes
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  NUM_CH*DATA_W  all channels written together
ram_rdata  in  NUM_CH*DATA_W  read data, valid 1 clk after ram_en & !ram_we
dout  out  DATA_W  readout sample
dout_vld  out  1  readout valid
dout_rdy  in  1  downstream accept
busy  out  1  state != IDLE/DONE
cap_done  out  1  capture complete flag
dump_fin  out  1  one-clock pulse after last readout sample accepted
auto_trig  out  1  last capture was forced (0 when macro absent)

Behaviour:
- Reset: all outputs 0, state IDLE, pointers/counters 0.
- trig_in: 2-flop synchronizer per bit; edge detect on cfg_trig_src per cfg_trig_edge; detected edge sets sticky trig_seen, cleared on each kept sample.
- Decimation: dec_cnt counts smpl_en; sample kept when dec_cnt==0; wraps at 2^cfg_decimator-1. cfg_decimator>MAX_DEC clamped to MAX_DEC. Config sampled at arm, held for the capture.
- Kept sample: ram_en=ram_we=1 for that clock, ram_addr=wr_ptr, ram_wdata=smpl_data (same cycle); wr_ptr increments, wraps DEPTH-1 -> 0.
- States: IDLE -arm-> PRE; PRE: write, pre_cnt counts; when pre_cnt == DEPTH-1-cfg_trig_pos -> ARMED (directly if 0). ARMED: write; kept sample with trig_seen is the trigger sample -> POST (post_cnt=0), or -> DONE if cfg_trig_pos==0. POST: write; post_cnt==cfg_trig_pos after write -> DONE. Edges during PRE are discarded.
- DONE entry: start_addr <= wr_ptr (oldest sample); cap_done set.
- cap_done: set on DONE entry; cleared by clr_cap_done or arm; set and clear same clock -> set wins.
- arm in any state except DUMP: aborts, restarts at PRE, wr_ptr=0. arm during DUMP ignored. dump outside DONE ignored.
- DUMP: rd_ptr=start_addr, count DEPTH samples of dump_ch. One read in flight: ram_en=1, ram_we=0, ram_addr=rd_ptr; next clock capture ram_rdata slice into dout, dout_vld=1; hold dout/dout_vld stable until dout_rdy; on handshake issue next read (throughput 1 sample / 2 clk max). rd_ptr wraps. After DEPTH-th handshake: dump_fin pulses, -> DONE, cap_done stays 1.
- Writes and reads never overlap (dump only in DONE).

Optional Feature:
AUTO_TRIG_EN: when defined, ARMED counts kept samples; reaching AUTO_TIMEOUT without trigger forces the current kept sample as trigger sample and sets auto_trig (cleared at arm). Not defined: ARMED waits indefinitely, auto_trig tied 0.

Test Plan:
- DEPTH=16, dec=0, trig_pos=4, ramp data 0,1,2..., rising edge on trig_in[0] after sample 20 -> cap_done; dump streams 16 consecutive values ending trigger_sample+4.
- dec=2, 64 smpl_en pulses -> exactly 16 RAM writes, on pulses 0,4,8,...
- Trigger edge during PRE (before 11 kept samples with trig_pos=4) -> ignored; capture completes only on later edge.
- dump with dout_rdy low 5 clocks mid-stream -> dout/dout_vld stable, no sample lost/duplicated; dump_fin single pulse after 16th.
- clr_cap_done and DONE entry same clock -> cap_done=1; arm mid-POST -> cap_done 0, wr_ptr 0, restarts PRE.
- AUTO_TRIG_EN, AUTO_TIMEOUT=32, no edges -> forced trigger at 32nd ARMED kept sample, auto_trig=1, normal completion.
